// File: rtl/gost_round.sv
// gost_round: one Magma (GOST 28147-89 / GOST R 34.12-2015) Feistel round, computed in four
// cycles behind a start/done handshake. A cipher controller iterates it and sequences keys.
//
// Ports:
//   iclk    in   1  clock, rising edge
//   irst    in   1  asynchronous active-low reset
//   istart  in   1  start request, sampled only while idle
//   iblock  in  64  {N2, N1} input block, sampled with istart
//   ikey    in  32  round key, sampled with istart
//   oblock  out 64  {N1, N2 ^ g}, held until the next completion
//   odone   out  1  one-cycle completion pulse
module gost_round (
  input  logic        iclk,
  input  logic        irst,
  input  logic        istart,
  input  logic [63:0] iblock,
  input  logic [31:0] ikey,
  output logic [63:0] oblock,
  output logic        odone
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAdd  = 2'd1;
  localparam logic [1:0] StSub  = 2'd2;
  localparam logic [1:0] StOut  = 2'd3;

  // id-tc26-gost-28147-param-Z; row i serves nibble i (bits [4i+3:4i]).
  localparam logic [3:0] SBOX [8][16] = '{
    '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9,
      4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
    '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC,
      4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
    '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD,
      4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
    '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6,
      4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
    '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD,
      4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
    '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA,
      4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
    '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC,
      4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
    '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3,
      4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
  };

  logic [1:0]  state_q, state_d;
  logic [31:0] n1_q, n1_d;
  logic [31:0] n2_q, n2_d;
  logic [31:0] key_q, key_d;
  logic [31:0] sum_q, sum_d;
  logic [31:0] sub_q, sub_d;
  logic [63:0] block_q, block_d;
  logic        done_q, done_d;

  logic [31:0] sub_word;
  logic [31:0] rot_word;

  always_comb begin
    sub_word = '0;
    for (int i = 0; i < 8; i++) begin
      sub_word[4*i +: 4] = SBOX[i][sum_q[4*i +: 4]];
    end
  end

  assign rot_word = {sub_q[20:0], sub_q[31:21]};

  always_comb begin
    state_d = state_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    key_d   = key_q;
    sum_d   = sum_q;
    sub_d   = sub_q;
    block_d = block_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (istart) begin
          n1_d    = iblock[31:0];
          n2_d    = iblock[63:32];
          key_d   = ikey;
          state_d = StAdd;
        end
      end
      StAdd: begin
        sum_d   = n1_q + key_q;  // carry out discarded: mod 2^32
        state_d = StSub;
      end
      StSub: begin
        sub_d   = sub_word;
        state_d = StOut;
      end
      StOut: begin
        block_d = {n1_q, n2_q ^ rot_word};
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state_q <= StIdle;
      n1_q    <= '0;
      n2_q    <= '0;
      key_q   <= '0;
      sum_q   <= '0;
      sub_q   <= '0;
      block_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      key_q   <= key_d;
      sum_q   <= sum_d;
      sub_q   <= sub_d;
      block_q <= block_d;
      done_q  <= done_d;
    end
  end

  assign oblock = block_q;
  assign odone  = done_q;

endmodule

// File: tb/tb_gost_round.sv
// Directed bench for gost_round: known Magma round vectors, latency, back-to-back, reset abort.
module tb_gost_round;

  logic        iclk;
  logic        irst;
  logic        istart;
  logic [63:0] iblock;
  logic [31:0] ikey;
  logic [63:0] oblock;
  logic        odone;

  int n_vec;
  int n_fail;

  localparam logic [63:0] BlkMagma = 64'h76543210_FEDCBA98;
  localparam logic [31:0] KeyMagma = 32'h87654321;
  localparam logic [63:0] ExpMagma = 64'hFEDCBA98_8B9FF01C;
  localparam logic [63:0] BlkChain = 64'h00000000_87654321;
  localparam logic [31:0] KeyChain = 32'hFDCBC20C;
  localparam logic [63:0] ExpChain = 64'h87654321_7E791A4B;
  localparam logic [63:0] BlkCarry = 64'h00000000_FFFFFFFF;
  localparam logic [31:0] KeyCarry = 32'h00000001;
  localparam logic [63:0] ExpCarry = 64'hFFFFFFFF_BE5B60C2;

  gost_round dut (
    .iclk   (iclk),
    .irst   (irst),
    .istart (istart),
    .iblock (iblock),
    .ikey   (ikey),
    .oblock (oblock),
    .odone  (odone)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic test_reset();
    irst   = 1'b0;
    istart = 1'b0;
    iblock = '0;
    ikey   = '0;
    #3;
    n_vec++;
    if (oblock !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_oblock: got %h want %h", oblock, 64'h0);
    end
    n_vec++;
    if (odone !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_odone: got %b want 0", odone);
    end
    tick();
    tick();
    irst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_vec++;
      if (odone !== 1'b0 || oblock !== 64'h0) begin
        n_fail++;
        $display("FAIL idle_quiet cycle %0d: odone=%b oblock=%h want 0/0", c, odone, oblock);
      end
    end
  endtask

  // One isolated round; inputs are scrambled after E0 to prove the latched copies are used.
  task automatic run_single(input string name, input logic [63:0] blk, input logic [31:0] key,
                            input logic [63:0] exp);
    istart = 1'b1;
    iblock = blk;
    ikey   = key;
    tick();  // E0
    istart = 1'b0;
    iblock = ~blk;
    ikey   = ~key;
    n_vec++;
    if (odone !== 1'b0) begin
      n_fail++;
      $display("FAIL %s odone_E0: got %b want 0", name, odone);
    end
    for (int e = 1; e <= 2; e++) begin
      if (e == 2) istart = 1'b1;  // ignored outside idle
      tick();
      n_vec++;
      if (odone !== 1'b0) begin
        n_fail++;
        $display("FAIL %s odone_E%0d: got %b want 0", name, e, odone);
      end
    end
    istart = 1'b0;
    tick();  // E3
    n_vec++;
    if (odone !== 1'b1) begin
      n_fail++;
      $display("FAIL %s odone_E3: got %b want 1", name, odone);
    end
    n_vec++;
    if (oblock !== exp) begin
      n_fail++;
      $display("FAIL %s oblock_E3: got %h want %h", name, oblock, exp);
    end
    tick();  // E4
    n_vec++;
    if (odone !== 1'b0 || oblock !== exp) begin
      n_fail++;
      $display("FAIL %s hold_E4: odone=%b oblock=%h want 0/%h", name, odone, oblock, exp);
    end
    tick();
    tick();
    n_vec++;
    if (odone !== 1'b0) begin
      n_fail++;
      $display("FAIL %s no_requeue: odone=%b want 0", name, odone);
    end
  endtask

  task automatic test_magma_vector();
    run_single("magma", BlkMagma, KeyMagma, ExpMagma);
  endtask

  task automatic test_chained_vector();
    run_single("chain", BlkChain, KeyChain, ExpChain);
  endtask

  task automatic test_carry_wrap();
    run_single("carry", BlkCarry, KeyCarry, ExpCarry);
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    logic        exp_done;
    istart = 1'b1;
    iblock = BlkMagma;
    ikey   = KeyMagma;
    tick();  // E0
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e == 1) begin
        iblock = BlkChain;
        ikey   = KeyChain;
      end
      if (e == 5) begin
        iblock = BlkCarry;
        ikey   = KeyCarry;
      end
      exp_done = (e == 3) || (e == 7) || (e == 11);
      n_vec++;
      if (odone !== exp_done) begin
        n_fail++;
        $display("FAIL b2b odone_E%0d: got %b want %b", e, odone, exp_done);
      end
      if (exp_done) begin
        exp = (e == 3) ? ExpMagma : (e == 7) ? ExpChain : ExpCarry;
        n_vec++;
        if (oblock !== exp) begin
          n_fail++;
          $display("FAIL b2b oblock_E%0d: got %h want %h", e, oblock, exp);
        end
      end
    end
    istart = 1'b0;
    tick();  // E12
    n_vec++;
    if (odone !== 1'b0 || oblock !== ExpCarry) begin
      n_fail++;
      $display("FAIL b2b tail: odone=%b oblock=%h want 0/%h", odone, oblock, ExpCarry);
    end
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_reset_mid_round();
    istart = 1'b1;
    iblock = BlkMagma;
    ikey   = KeyMagma;
    tick();  // E0
    istart = 1'b0;
    tick();  // E1
    irst = 1'b0;
    #1;
    n_vec++;
    if (oblock !== 64'h0 || odone !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_clear: oblock=%h odone=%b want 0/0", oblock, odone);
    end
    tick();
    tick();
    irst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_vec++;
      if (odone !== 1'b0 || oblock !== 64'h0) begin
        n_fail++;
        $display("FAIL midreset_abort cycle %0d: odone=%b oblock=%h want 0/0", c, odone, oblock);
      end
    end
    run_single("restart", BlkChain, KeyChain, ExpChain);
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    test_reset();
    test_magma_vector();
    test_chained_vector();
    test_carry_wrap();
    test_back_to_back();
    test_reset_mid_round();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
